// File: rtl/generic_fifo_pkg.sv
// Shared helpers for the multi-peek FIFO family.
// Width functions and the pipe_data slot slicing rule.
package generic_fifo_pkg;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Slot i of a flattened window lives at [slot_lsb(i, w) +: w].
    function automatic int slot_lsb(input int slot, input int width);
        return slot * width;
    endfunction

endpackage

// File: rtl/generic_multi_peek_store.sv
// Circular storage buffer behind the peek window.
// Head entry is combinationally readable; push is dropped when full.
module generic_multi_peek_store
    import generic_fifo_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int WIDTH     = 32,
    parameter int THRESHOLD = 6
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_clear,
    input  logic                        i_push,
    input  logic [WIDTH-1:0]            i_push_data,
    input  logic                        i_pop,
    output logic [WIDTH-1:0]            o_head_data,
    output logic                        o_empty,
    output logic                        o_full,
    output logic                        o_almost_full,
    output logic [cnt_width(DEPTH)-1:0] o_count
);

    localparam int PW = ptr_width(DEPTH);
    localparam int CW = cnt_width(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_flush;
    logic             w_push;
    logic             w_pop;

    assign w_flush = i_reset || i_clear;
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Pointer wrap relies on DEPTH being a power of two.
    always_ff @(posedge i_clk) begin
        if (w_push && !w_flush) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    assign o_head_data   = r_mem[r_rd_ptr];
    assign o_empty       = (r_count == '0);
    assign o_full        = (r_count == CW'(DEPTH));
    assign o_almost_full = (32'(r_count) >= THRESHOLD);
    assign o_count       = r_count;

endmodule

// File: rtl/generic_multi_peek_fifo.sv
// FIFO with a multi-entry peek window and 0..PEEK pops per cycle.
// Optional write bypass into the window: GENERIC_MULTI_PEEK_FIFO_BYPASS_EN.
module generic_multi_peek_fifo
    import generic_fifo_pkg::*;
#(
    parameter int GENERIC_FIFO_DEPTH      = 8,
    parameter int GENERIC_PEEK_DEPTH      = 3,
    parameter int GENERIC_FIFO_DATA_WIDTH = 32,
    parameter int GENERIC_FIFO_THRESHOLD  = 6
) (
    input  logic                                    clk,
    input  logic                                    reset_poweron,
    input  logic                                    clear,
    input  logic                                    write,
    input  logic [GENERIC_FIFO_DATA_WIDTH-1:0]      write_data,
    input  logic [cnt_width(GENERIC_PEEK_DEPTH)-1:0] pipe_read_count,
    output logic [GENERIC_PEEK_DEPTH-1:0]           pipe_valid,
    output logic [GENERIC_PEEK_DEPTH*GENERIC_FIFO_DATA_WIDTH-1:0] pipe_data,
    output logic                                    almost_full,
    output logic                                    full,
    output logic [cnt_width(GENERIC_FIFO_DEPTH+GENERIC_PEEK_DEPTH)-1:0] count,
    output logic                                    overflow,
    output logic                                    underflow
);

    localparam int P   = GENERIC_PEEK_DEPTH;
    localparam int W   = GENERIC_FIFO_DATA_WIDTH;
    localparam int RCW = cnt_width(P);
    localparam int SCW = cnt_width(GENERIC_FIFO_DEPTH);
    localparam int CW  = cnt_width(GENERIC_FIFO_DEPTH + P);

    logic [P-1:0]   r_valid;
    logic [P*W-1:0] r_data;
    logic           r_overflow;
    logic           r_underflow;

    logic [RCW-1:0] w_vcnt;
    logic [RCW-1:0] w_k;
    logic [RCW-1:0] w_left;
    logic           w_under;
    logic           w_slot_free;
    logic           w_refill;
    logic           w_bypass;
    logic [W-1:0]   w_fill_data;
    logic [P-1:0]   w_next_valid;
    logic [P*W-1:0] w_next_data;

    logic [W-1:0]   w_st_head;
    logic           w_st_empty;
    logic           w_st_full;
    logic           w_st_af;
    logic [SCW-1:0] w_st_count;

    generic_multi_peek_store #(
        .DEPTH     (GENERIC_FIFO_DEPTH),
        .WIDTH     (W),
        .THRESHOLD (GENERIC_FIFO_THRESHOLD)
    ) u_store (
        .i_clk         (clk),
        .i_reset       (reset_poweron),
        .i_clear       (clear),
        .i_push        (write && !w_bypass),
        .i_push_data   (write_data),
        .i_pop         (w_refill),
        .o_head_data   (w_st_head),
        .o_empty       (w_st_empty),
        .o_full        (w_st_full),
        .o_almost_full (w_st_af),
        .o_count       (w_st_count)
    );

    always_comb begin
        w_vcnt = '0;
        for (int i = 0; i < P; i++) begin
            w_vcnt = w_vcnt + RCW'(r_valid[i]);
        end

        w_under     = (pipe_read_count > w_vcnt);
        w_k         = w_under ? w_vcnt : pipe_read_count;
        w_left      = w_vcnt - w_k;
        w_slot_free = (int'(w_left) < P);

`ifdef GENERIC_MULTI_PEEK_FIFO_BYPASS_EN
        w_bypass = w_slot_free && w_st_empty && write;
`else
        w_bypass = 1'b0;
`endif
        w_refill    = w_slot_free && !w_st_empty;
        w_fill_data = w_bypass ? write_data : w_st_head;

        // Shift down by k; each shift amount is unrolled so indices stay constant.
        w_next_valid = '0;
        w_next_data  = '0;
        for (int kk = 0; kk <= P; kk++) begin
            if (int'(w_k) == kk) begin
                for (int i = 0; i + kk < P; i++) begin
                    w_next_valid[i] = r_valid[i+kk];
                    w_next_data[slot_lsb(i, W) +: W] =
                        r_data[slot_lsb(i + kk, W) +: W];
                end
            end
        end

        if (w_refill || w_bypass) begin
            for (int j = 0; j < P; j++) begin
                if (int'(w_left) == j) begin
                    w_next_valid[j] = 1'b1;
                    w_next_data[slot_lsb(j, W) +: W] = w_fill_data;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset_poweron || clear) begin
            r_valid     <= '0;
            r_data      <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_valid <= w_next_valid;
            r_data  <= w_next_data;
            if (write && w_st_full) begin
                r_overflow <= 1'b1;
            end
            if (w_under) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign pipe_valid  = r_valid;
    assign pipe_data   = r_data;
    assign almost_full = w_st_af;
    assign full        = w_st_full;
    assign count       = CW'(w_st_count) + CW'(w_vcnt);
    assign overflow    = r_overflow;
    assign underflow   = r_underflow;

endmodule

// File: tb/tb_generic_multi_peek_fifo.sv
// Directed self-checking bench for generic_multi_peek_fifo.
// DEPTH=8, PEEK=3, W=8, THRESHOLD=6.
module tb_generic_multi_peek_fifo;

    logic        clk = 1'b0;
    logic        reset_poweron;
    logic        clear;
    logic        write;
    logic [7:0]  write_data;
    logic [1:0]  pipe_read_count;
    logic [2:0]  pipe_valid;
    logic [23:0] pipe_data;
    logic        almost_full;
    logic        full;
    logic [3:0]  count;
    logic        overflow;
    logic        underflow;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    generic_multi_peek_fifo #(
        .GENERIC_FIFO_DEPTH      (8),
        .GENERIC_PEEK_DEPTH      (3),
        .GENERIC_FIFO_DATA_WIDTH (8),
        .GENERIC_FIFO_THRESHOLD  (6)
    ) dut (
        .clk             (clk),
        .reset_poweron   (reset_poweron),
        .clear           (clear),
        .write           (write),
        .write_data      (write_data),
        .pipe_read_count (pipe_read_count),
        .pipe_valid      (pipe_valid),
        .pipe_data       (pipe_data),
        .almost_full     (almost_full),
        .full            (full),
        .count           (count),
        .overflow        (overflow),
        .underflow       (underflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] slot(input int i);
        return 32'(pipe_data[i*8 +: 8]);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        write           = 1'b0;
        clear           = 1'b0;
        pipe_read_count = 2'd0;
    endtask

    initial begin
        reset_poweron = 1'b1;
        write_data    = 8'h00;
        idle();
        tick();
        tick();
        reset_poweron = 1'b0;

        chk("rst_valid", 32'(pipe_valid), 0);
        chk("rst_data", 32'(pipe_data), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_full", 32'(full), 0);
        chk("rst_afull", 32'(almost_full), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_unf", 32'(underflow), 0);

        // single entry: two-cycle latency
        write      = 1'b1;
        write_data = 8'h11;
        tick();
        idle();
        chk("single_c1_valid", 32'(pipe_valid), 0);
        chk("single_c1_count", 32'(count), 1);
        tick();
        chk("single_c2_valid", 32'(pipe_valid), 1);
        chk("single_c2_slot0", slot(0), 32'h11);
        chk("single_c2_count", 32'(count), 1);
        pipe_read_count = 2'd1;
        tick();
        idle();
        chk("single_pop_valid", 32'(pipe_valid), 0);
        chk("single_pop_count", 32'(count), 0);

        // multi-pop
        for (int i = 1; i <= 5; i++) begin
            write      = 1'b1;
            write_data = 8'(i);
            tick();
        end
        idle();
        chk("mp_valid", 32'(pipe_valid), 7);
        chk("mp_slot0", slot(0), 1);
        chk("mp_slot1", slot(1), 2);
        chk("mp_slot2", slot(2), 3);
        chk("mp_count", 32'(count), 5);
        pipe_read_count = 2'd2;
        tick();
        idle();
        chk("mp_pop2_slot0", slot(0), 3);
        chk("mp_pop2_slot1", slot(1), 4);
        chk("mp_pop2_valid", 32'(pipe_valid), 3);
        chk("mp_pop2_count", 32'(count), 3);
        tick();
        chk("mp_refill_valid", 32'(pipe_valid), 7);
        chk("mp_refill_slot2", slot(2), 5);
        chk("mp_refill_count", 32'(count), 3);
        pipe_read_count = 2'd3;
        tick();
        idle();
        chk("mp_pop3_valid", 32'(pipe_valid), 0);
        chk("mp_pop3_count", 32'(count), 0);
        chk("mp_pop3_unf", 32'(underflow), 0);

        // full and overflow
        for (int i = 0; i < 11; i++) begin
            write      = 1'b1;
            write_data = 8'h20 + 8'(i);
            tick();
            if (i == 7) begin
                chk("fill_afull_lo", 32'(almost_full), 0);
            end
            if (i == 8) begin
                chk("fill_afull_hi", 32'(almost_full), 1);
                chk("fill_notfull", 32'(full), 0);
            end
        end
        chk("fill_full", 32'(full), 1);
        chk("fill_count", 32'(count), 11);
        chk("fill_ovf0", 32'(overflow), 0);
        write_data = 8'hEE;
        tick();
        idle();
        chk("ovf_set", 32'(overflow), 1);
        chk("ovf_count", 32'(count), 11);
        chk("ovf_full", 32'(full), 1);
        for (int i = 0; i < 11; i++) begin
            chk("drain_order", slot(0), 32'(32'h20 + i));
            chk("drain_valid0", 32'(pipe_valid[0]), 1);
            pipe_read_count = 2'd1;
            tick();
            pipe_read_count = 2'd0;
        end
        chk("drain_count", 32'(count), 0);
        chk("drain_full", 32'(full), 0);
        chk("drain_afull", 32'(almost_full), 0);
        chk("drain_ovf_sticky", 32'(overflow), 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clear_ovf", 32'(overflow), 0);

        // underflow
        write      = 1'b1;
        write_data = 8'h33;
        tick();
        idle();
        tick();
        chk("unf_pre_valid", 32'(pipe_valid), 1);
        pipe_read_count = 2'd3;
        tick();
        idle();
        chk("unf_valid", 32'(pipe_valid), 0);
        chk("unf_set", 32'(underflow), 1);
        chk("unf_count", 32'(count), 0);

        // clear mid-stream with write and read
        for (int i = 0; i < 4; i++) begin
            write      = 1'b1;
            write_data = 8'h41 + 8'(i);
            tick();
        end
        idle();
        chk("cm_pre_count", 32'(count), 4);
        chk("cm_pre_unf", 32'(underflow), 1);
        clear           = 1'b1;
        write           = 1'b1;
        write_data      = 8'h55;
        pipe_read_count = 2'd1;
        tick();
        idle();
        chk("cm_valid", 32'(pipe_valid), 0);
        chk("cm_data", 32'(pipe_data), 0);
        chk("cm_count", 32'(count), 0);
        chk("cm_full", 32'(full), 0);
        chk("cm_afull", 32'(almost_full), 0);
        chk("cm_ovf", 32'(overflow), 0);
        chk("cm_unf", 32'(underflow), 0);
        tick();
        chk("cm_after_valid", 32'(pipe_valid), 0);
        chk("cm_after_count", 32'(count), 0);

        // empty-FIFO write latency
        write      = 1'b1;
        write_data = 8'hAA;
        tick();
        idle();
`ifdef GENERIC_MULTI_PEEK_FIFO_BYPASS_EN
        chk("byp_c1_valid", 32'(pipe_valid), 1);
        chk("byp_c1_slot0", slot(0), 32'hAA);
        chk("byp_c1_count", 32'(count), 1);
`else
        chk("lat_c1_valid", 32'(pipe_valid), 0);
        chk("lat_c1_count", 32'(count), 1);
`endif
        tick();
        chk("lat_c2_valid", 32'(pipe_valid), 1);
        chk("lat_c2_slot0", slot(0), 32'hAA);
        chk("lat_c2_count", 32'(count), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
